// File: rtl/vga_fb_fetch_arb.sv
// Single-port frame-buffer arbiter: the VGA line fetch (deadline, always wins) fills a
// ping-pong line buffer; a pixel writer gets the memory only when no fetch is pending.
module vga_fb_fetch_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 18,
    parameter int LINE_W     = 10,
    parameter int LINE_WORDS = 160,
    parameter int MAX_OUT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_req,
    input  logic [LINE_W-1:0] line_idx,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [7:0]        lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              fetch_done,
    output logic              disp_bank,
    output logic              overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]        r_state;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [ADDR_W-1:0] r_start;
    logic [7:0]        r_issue_cnt;
    logic [7:0]        r_wr_cnt;
    logic [2:0]        r_out;
    logic              r_done;
    logic              r_lb_bank;
    logic              r_disp_bank;
    logic              r_overrun;

    logic [ADDR_W-1:0] w_req_addr;
    logic [ADDR_W-1:0] w_next_start;
    logic              w_fetch_go;
    logic              w_busy;
    logic              w_rd_req;
    logic              w_wr_req;
    logic              w_rd_hs;
    logic              w_rv;
    logic              w_last_wr;

    // Start address wraps modulo 2^ADDR_W by construction of the operand widths.
    assign w_req_addr   = fb_base + ADDR_W'(line_idx) * ADDR_W'(LINE_WORDS);
    // A request arriving in IDLE is honoured in the same cycle, so it beats a concurrent wr_req.
    assign w_fetch_go   = r_pend | line_req;
    assign w_next_start = line_req ? w_req_addr : r_pend_addr;

    assign w_busy    = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_rd_req  = (r_state == S_FETCH) && (r_out < 3'(MAX_OUT));
    assign w_wr_req  = (r_state == S_WRITE) && wr_req;
    assign w_rd_hs   = w_rd_req && mem_ready;
    assign w_rv      = mem_rvalid && w_busy;
    assign w_last_wr = w_rv && (r_wr_cnt == 8'(LINE_WORDS - 1));

    assign mem_req    = w_rd_req | w_wr_req;
    assign mem_we     = w_wr_req;
    assign mem_addr   = w_rd_req ? (r_start + ADDR_W'(r_issue_cnt)) :
                        w_wr_req ? wr_addr : '0;
    assign mem_wdata  = w_wr_req ? wr_data : '0;
    assign wr_ack     = w_wr_req && mem_ready;

    assign lb_we      = w_rv;
    assign lb_addr    = w_rv ? r_wr_cnt : '0;
    assign lb_wdata   = w_rv ? mem_rdata : '0;
    assign lb_bank    = r_lb_bank;
    assign fetch_done = r_done;
    assign disp_bank  = r_disp_bank;
    assign overrun    = r_overrun;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order within the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_start     <= '0;
            r_issue_cnt <= '0;
            r_wr_cnt    <= '0;
            r_out       <= '0;
            r_done      <= 1'b0;
            r_lb_bank   <= 1'b0;
            r_disp_bank <= 1'b1;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (line_req) begin
                r_pend_addr <= w_req_addr;
                if (r_pend || w_busy) r_overrun <= 1'b1;
            end
            if (line_req && (r_state != S_IDLE)) r_pend <= 1'b1;
            else if (r_state == S_IDLE)          r_pend <= 1'b0;

            case ({w_rd_hs, w_rv})
                2'b10:   r_out <= r_out + 3'd1;
                2'b01:   r_out <= r_out - 3'd1;
                default: r_out <= r_out;
            endcase
            if (w_rd_hs) r_issue_cnt <= r_issue_cnt + 8'd1;
            if (w_rv)    r_wr_cnt    <= r_wr_cnt + 8'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_fetch_go) begin
                        r_state     <= S_FETCH;
                        r_start     <= w_next_start;
                        r_issue_cnt <= '0;
                        r_wr_cnt    <= '0;
                    end else if (wr_req) begin
                        r_state <= S_WRITE;
                    end
                end
                S_FETCH: begin
                    if (w_rd_hs && (r_issue_cnt == 8'(LINE_WORDS - 1))) r_state <= S_DRAIN;
                end
                S_WRITE: begin
                    if (!wr_req || mem_ready) r_state <= S_IDLE;
                end
                default: r_state <= r_state;
            endcase

            // Last beat written: hand the filled bank to the display and swap.
            if (w_last_wr) begin
                r_done      <= 1'b1;
                r_disp_bank <= r_lb_bank;
                r_lb_bank   <= ~r_lb_bank;
                r_state     <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_fetch_arb.sv
// Directed bench for vga_fb_fetch_arb: an in-order memory model with programmable latency
// and ready pattern, plus logs of commands, line-buffer writes, fetch_done and wr_ack.
module tb_vga_fb_fetch_arb;

    logic        clk;
    logic        rst;
    logic        line_req;
    logic [9:0]  line_idx;
    logic [17:0] fb_base;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        lb_we;
    logic        lb_bank;
    logic [7:0]  lb_addr;
    logic [31:0] lb_wdata;
    logic        fetch_done;
    logic        disp_bank;
    logic        overrun;

    vga_fb_fetch_arb #(
        .DATA_W(32), .ADDR_W(18), .LINE_W(10), .LINE_WORDS(160), .MAX_OUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .line_req(line_req), .line_idx(line_idx), .fb_base(fb_base),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .fetch_done(fetch_done), .disp_bank(disp_bank), .overrun(overrun)
    );

    typedef struct { logic [17:0] addr; int due; } rd_t;
    typedef struct { logic bank; logic [7:0] addr; logic [31:0] data; } lb_t;

    // Written only by the memory/monitor process.
    rd_t         rq[$];
    logic [17:0] rd_log[$];
    lb_t         lb_log[$];
    logic [17:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    int cyc, done_cnt, ack_cnt, done_cyc, ack_cyc, tb_out, max_out, stable_err;
    logic        p_req, p_rdy, p_we;
    logic [17:0] p_addr;
    logic [31:0] p_wdata;

    // Written only by the stimulus process.
    int lat, ready_mode, stray_until;
    bit chk_stable, track_max;

    int n_err, n_chk;

    function automatic logic [31:0] mdata(input logic [17:0] a);
        return {14'h2A5A, a};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model and monitor: drive at the falling edge, observe 2 ns later.
    initial begin : mem_model
        cyc = 0; done_cnt = 0; ack_cnt = 0; done_cyc = 0; ack_cyc = 0;
        tb_out = 0; max_out = 0; stable_err = 0;
        p_req = 1'b0; p_rdy = 1'b1; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = (cyc % 2 == 1);
                default: mem_ready = 1'b0;
            endcase
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mdata(rq[0].addr);
                void'(rq.pop_front());
                tb_out--;
            end else if (cyc < stray_until) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            #2;
            if (chk_stable && p_req && !p_rdy && !rst &&
                !(mem_req && mem_we == p_we && mem_addr == p_addr && mem_wdata == p_wdata))
                stable_err++;
            p_req = mem_req; p_rdy = mem_ready; p_we = mem_we;
            p_addr = mem_addr; p_wdata = mem_wdata;
            if (mem_req && mem_ready && !mem_we) begin
                rq.push_back('{mem_addr, cyc + lat});
                rd_log.push_back(mem_addr);
                tb_out++;
                if (track_max && tb_out > max_out) max_out = tb_out;
            end
            if (mem_req && mem_ready && mem_we) begin
                wlog_addr.push_back(mem_addr);
                wlog_data.push_back(mem_wdata);
            end
            if (lb_we) lb_log.push_back('{lb_bank, lb_addr, lb_wdata});
            if (fetch_done) begin done_cnt++; done_cyc = cyc; end
            if (wr_ack)     begin ack_cnt++;  ack_cyc  = cyc; end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_line(input logic [9:0] idx, input logic [17:0] base);
        @(negedge clk);
        line_idx = idx; fb_base = base; line_req = 1'b1;
        @(negedge clk);
        line_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 3000 && done_cnt < target; i++) begin
            @(negedge clk); #3;
        end
        check(tag, done_cnt, target);
    endtask

    task automatic wait_ack(input string tag, input int target);
        for (int i = 0; i < 200 && ack_cnt < target; i++) begin
            @(negedge clk); #3;
        end
        check(tag, ack_cnt, target);
    endtask

    task automatic verify_line(input string tag, input int rd_off, input int lb_off,
                               input logic [17:0] start, input logic bank);
        int err;
        logic [17:0] a;
        err = 0;
        check({tag, "_nrd"}, rd_log.size() >= rd_off + 160, 1'b1);
        check({tag, "_nlb"}, lb_log.size() >= lb_off + 160, 1'b1);
        if (rd_log.size() >= rd_off + 160 && lb_log.size() >= lb_off + 160) begin
            check({tag, "_first"}, rd_log[rd_off], start);
            for (int i = 0; i < 160; i++) begin
                a = start + 18'(i);
                if (rd_log[rd_off + i] !== a) err++;
                if (lb_log[lb_off + i].bank !== bank || lb_log[lb_off + i].addr !== 8'(i) ||
                    lb_log[lb_off + i].data !== mdata(a)) err++;
            end
        end else begin
            err = 999;
        end
        check({tag, "_words"}, err, 0);
    endtask

    initial begin : stim
        int rd_b, lb_b, d_b, a_b, w_b;
        n_err = 0; n_chk = 0;
        lat = 2; ready_mode = 0; stray_until = 0; chk_stable = 1'b1; track_max = 1'b0;
        rst = 1'b1; line_req = 1'b0; line_idx = '0; fb_base = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #4;
        check("rst_flags", {mem_req, mem_we, wr_ack, lb_we, fetch_done, overrun, lb_bank}, 7'd0);
        check("rst_mem_addr", mem_addr, 18'h0);
        check("rst_disp_bank", disp_bank, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Fetch line 2 at base 0x100, always-ready memory, latency 2
        rd_b = rd_log.size(); lb_b = lb_log.size(); d_b = done_cnt;
        fetch_line(10'd2, 18'h00100);
        wait_done("t1_done", d_b + 1);
        check("t1_disp_bank", disp_bank, 1'b0);
        check("t1_lb_bank", lb_bank, 1'b1);
        repeat (4) @(negedge clk);
        check("t1_nreads", rd_log.size() - rd_b, 160);
        check("t1_done_once", done_cnt - d_b, 1);
        verify_line("t1", rd_b, lb_b, 18'h00240, 1'b0);
        check("t1_last_addr", rd_log[rd_b + 159], 18'h002DF);
        check("t1_overrun", overrun, 1'b0);

        // Backpressure: ready toggles, latency 6; line 7 at base 0 -> 0x460, bank 1
        ready_mode = 1; lat = 6; track_max = 1'b1;
        rd_b = rd_log.size(); lb_b = lb_log.size(); d_b = done_cnt;
        fetch_line(10'd7, 18'h00000);
        wait_done("t2_done", d_b + 1);
        track_max = 1'b0;
        check("t2_max_out_le4", max_out <= 4, 1'b1);
        check("t2_max_out_gt1", max_out > 1, 1'b1);
        check("t2_stable", stable_err, 0);
        verify_line("t2", rd_b, lb_b, 18'h00460, 1'b1);
        check("t2_banks", {disp_bank, lb_bank}, 2'b10);

        // Priority: line_req and wr_req in the same IDLE cycle
        ready_mode = 0; lat = 2;
        repeat (3) @(negedge clk);
        rd_b = rd_log.size(); lb_b = lb_log.size(); d_b = done_cnt; a_b = ack_cnt;
        w_b = wlog_addr.size();
        @(negedge clk);
        line_idx = 10'd1; fb_base = 18'h00000; line_req = 1'b1;
        wr_req = 1'b1; wr_addr = 18'h12345; wr_data = 32'hCAFE_F00D;
        @(negedge clk);
        line_req = 1'b0;
        wait_ack("t3_ack", a_b + 1);
        @(negedge clk);
        wr_req = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_done_before_ack", done_cnt - d_b, 1);
        check("t3_ack_after_done", ack_cyc > done_cyc, 1'b1);
        check("t3_one_ack", ack_cnt - a_b, 1);
        check("t3_waddr", wlog_addr[w_b], 18'h12345);
        verify_line("t3", rd_b, lb_b, 18'h000A0, 1'b0);

        // Write in an IDLE gap under toggling ready: 0x3FFFF, one ack, command held stable
        ready_mode = 1;
        a_b = ack_cnt; w_b = wlog_addr.size();
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 18'h3FFFF; wr_data = 32'h1357_2468;
        wait_ack("t3b_ack", a_b + 1);
        @(negedge clk);
        wr_req = 1'b0;
        repeat (4) @(negedge clk);
        check("t3b_one_ack", ack_cnt - a_b, 1);
        check("t3b_nwrites", wlog_addr.size() - w_b, 1);
        check("t3b_waddr", wlog_addr[w_b], 18'h3FFFF);
        check("t3b_wdata", wlog_data[w_b], 32'h1357_2468);
        check("t3b_stable", stable_err, 0);

        // Writer withdraws while the memory stalls: no write, no ack
        ready_mode = 2;
        a_b = ack_cnt; w_b = wlog_addr.size();
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 18'h00ABC; wr_data = 32'h0BAD_F00D;
        repeat (3) @(negedge clk);
        #4;
        check("t3c_held_cmd", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 18'h00ABC, 32'h0BAD_F00D});
        check("t3c_stable", stable_err, 0);
        @(negedge clk);
        chk_stable = 1'b0; wr_req = 1'b0;
        repeat (2) @(negedge clk);
        ready_mode = 0;
        repeat (3) @(negedge clk);
        chk_stable = 1'b1;
        check("t3c_no_ack", ack_cnt - a_b, 0);
        check("t3c_no_write", wlog_addr.size() - w_b, 0);

        // Overrun: line 5 requested mid-fetch of line 4
        rd_b = rd_log.size(); lb_b = lb_log.size(); d_b = done_cnt;
        fetch_line(10'd4, 18'h00000);
        repeat (20) @(negedge clk);
        #4;
        check("t4_ovr_before", overrun, 1'b0);
        fetch_line(10'd5, 18'h00000);
        #4;
        check("t4_ovr_set", overrun, 1'b1);
        wait_done("t4_done", d_b + 2);
        repeat (4) @(negedge clk);
        check("t4_ovr_sticky", overrun, 1'b1);
        verify_line("t4_l4", rd_b, lb_b, 18'h00280, 1'b1);
        verify_line("t4_l5", rd_b + 160, lb_b + 160, 18'h00320, 1'b0);
        check("t4_banks", {disp_bank, lb_bank}, 2'b01);

        // Address wrap: 0x3FF00 + 3*160 -> 0x000E0
        rd_b = rd_log.size(); lb_b = lb_log.size(); d_b = done_cnt;
        fetch_line(10'd3, 18'h3FF00);
        wait_done("t5_done", d_b + 1);
        verify_line("t5", rd_b, lb_b, 18'h000E0, 1'b1);
        check("t5_ovr_sticky", overrun, 1'b1);

        // Reset after 50 words, then stray returns, then a clean fetch into bank 0
        lat = 4;
        lb_b = lb_log.size(); d_b = done_cnt;
        fetch_line(10'd0, 18'h01000);
        for (int i = 0; i < 400 && lb_log.size() < lb_b + 50; i++) begin
            @(negedge clk); #3;
        end
        check("t6_reached_50", lb_log.size() >= lb_b + 50, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #4;
        check("t6_rst_flags", {mem_req, mem_we, wr_ack, lb_we, fetch_done, overrun, lb_bank}, 7'd0);
        check("t6_rst_disp", disp_bank, 1'b1);
        lb_b = lb_log.size(); d_b = done_cnt;
        stray_until = cyc + 10;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60 && (rq.size() > 0 || cyc <= stray_until); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #4;
        check("t6_stray_ignored", lb_log.size() - lb_b, 0);
        check("t6_no_done", done_cnt - d_b, 0);
        check("t6_idle_after", {mem_req, lb_bank, disp_bank}, 3'b001);
        rd_b = rd_log.size(); lb_b = lb_log.size();
        fetch_line(10'd1, 18'h00000);
        wait_done("t6_done", d_b + 1);
        verify_line("t6", rd_b, lb_b, 18'h000A0, 1'b0);
        check("t6_banks", {disp_bank, lb_bank}, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_fb_fetch_arb.md
Name: vga_fb_fetch_arb

Overview:
- Arbitrates one single-port frame-buffer memory between two requesters.
- Requester 1 is the VGA display line fetch. It has a deadline and always has priority. Each line_req fills one bank of a ping-pong line buffer.
- Requester 2 is a pixel writer (pattern generator or host), served only when no fetch is pending.
- Sits between the VGA timing/counter block (which pulses line_req in horizontal blanking ahead of each active line) and the memory controller.

Parameters:
- DATA_W, 32, memory word width (4 pixels of 8 bits per word).
- ADDR_W, 18, memory word address width.
- LINE_W, 10, width of the line index.
- LINE_WORDS, 160, words fetched per line (640 px / 4).
- MAX_OUT, 4, maximum reads outstanding at the memory; range 1..7.

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  asynchronous active-high reset.
- line_req  in  1  1-cycle pulse: fetch line line_idx.
- line_idx  in  LINE_W  line to fetch; sampled when line_req=1.
- fb_base  in  ADDR_W  frame base address; sampled when line_req=1.
- wr_req  in  1  writer request; held until wr_ack.
- wr_addr  in  ADDR_W  writer word address.
- wr_data  in  DATA_W  writer data.
- wr_ack  out  1  1-cycle pulse: write accepted by memory.
- mem_req  out  1  memory command valid.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_W  command address.
- mem_wdata  out  DATA_W  write data.
- mem_ready  in  1  command accepted when mem_req and mem_ready are both 1.
- mem_rvalid  in  1  read data valid; reads return in order.
- mem_rdata  in  DATA_W  read data.
- lb_we  out  1  line-buffer write strobe.
- lb_bank  out  1  line-buffer bank being filled.
- lb_addr  out  8  word index within the line, 0..LINE_WORDS-1.
- lb_wdata  out  DATA_W  line-buffer data.
- fetch_done  out  1  1-cycle pulse after the last word is written.
- disp_bank  out  1  bank the display should read; toggles with fetch_done.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0. State=IDLE, counters 0, lb_bank=0, disp_bank=1.
- Fetch start address = fb_base + line_idx*LINE_WORDS, computed modulo 2^ADDR_W (wraps, no saturation).
- A 1-deep fetch-pending flag is set by line_req and cleared on entry to FETCH.
- If line_req arrives while the flag is already set, or while in FETCH/DRAIN:
  - set overrun (sticky until rst);
  - the new request replaces the pending one (latest line wins);
  - a fetch in progress is not aborted.
- State IDLE:
  - Pending fetch -> FETCH. Latch the start address, issue counter=0, write counter=0.
  - Else if wr_req -> WRITE.
  - A pending fetch always wins over wr_req in the same cycle.
- State FETCH:
  - mem_req=1, mem_we=0, mem_addr=start+issue_cnt whenever outstanding<MAX_OUT.
  - On mem_ready handshake: issue_cnt+1, outstanding+1.
  - Outstanding = issued minus returned; a handshake and a mem_rvalid in the same cycle net to 0.
  - After issue_cnt reaches LINE_WORDS -> DRAIN.
- State DRAIN: mem_req=0; wait for the remaining mem_rvalid beats.
- Read return (FETCH or DRAIN), on each mem_rvalid:
  - lb_we=1, lb_addr=wr_cnt, lb_wdata=mem_rdata, combinationally in the same cycle;
  - wr_cnt+1.
- Fetch completion:
  - The cycle after the write with wr_cnt=LINE_WORDS-1: fetch_done=1.
  - In that same cycle disp_bank<=lb_bank and lb_bank<=~lb_bank.
  - Then -> IDLE.
- State WRITE:
  - mem_req=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - On mem_ready: wr_ack=1 in that cycle, -> IDLE.
  - While mem_ready=0 the command is held stable. If wr_req drops before the handshake -> IDLE, no write occurs.
  - No fetch preemption here: a write in flight completes first.
  - Worst-case fetch delay = one write handshake.
- Writer throughput: at most one write per two cycles (WRITE then back to IDLE).
- A mem_rvalid outside FETCH/DRAIN is ignored.
- Reset mid-operation: immediate return to reset values. Outstanding reads returning after rst deassertion are ignored (state IDLE).
- Width checks: issue_cnt and wr_cnt are 8 bits (LINE_WORDS<=256); the outstanding counter is 3 bits.

Test Plan:
- Fetch, always-ready memory:
  - Stimulus: line_req with line_idx=2, fb_base=0x100; mem_ready=1; memory with 2-cycle read latency.
  - Required: 160 reads at addr 0x240..0x2DF.
  - Required: lb_addr 0..159 written to bank 0 in order.
  - Required: fetch_done once; afterwards disp_bank=0, lb_bank=1.
- Backpressure: mem_ready toggling 1/0 and rvalid delay 6 with MAX_OUT=4 -> outstanding never exceeds 4; no command changes while mem_ready=0; all 160 words correct.
- Priority:
  - Stimulus: wr_req and line_req in the same IDLE cycle.
  - Required: FETCH is entered first; wr_ack comes only after fetch_done.
  - Stimulus: wr_req held during an IDLE gap.
  - Required: write to wr_addr=0x3FFFF with the given data, one wr_ack pulse.
- Overrun:
  - Stimulus: a second line_req (line 5) mid-fetch of line 4.
  - Required: overrun=1 and stays 1.
  - Required: after line 4 finishes, line 5 is fetched into the opposite bank.
- Address wrap: fb_base=0x3FF00, line_idx=3 -> start address (0x3FF00+480) mod 2^18 = 0x000E0.
- Reset mid-fetch:
  - Stimulus: assert rst after 50 words; release; then inject stray rvalid beats.
  - Required: all outputs 0, disp_bank=1, stray rvalid beats ignored.
  - Required: the next line_req fetches cleanly into bank 0.
